// File: rtl/updown_mod_counter_pkg.sv
// updown_mod_counter_pkg: shared mode constants and modulus helpers for the up/down modulo counter.
package updown_mod_counter_pkg;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    function automatic int max_cnt(int modulus);
        return modulus - 1;
    endfunction

    function automatic bit modulus_ok(int width, int modulus);
        return modulus >= 2 && modulus <= 2 ** width;
    endfunction

endpackage

// File: rtl/updown_mod_counter_range_end_detect.sv
// range_end_detect: combinational terminal-count, next-count and range-end event logic.
module range_end_detect
    import updown_mod_counter_pkg::*;
#(
    parameter int             WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_CNT = 4'd9,
    parameter bit             SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             up_i,
    input  logic             ce_i,
    output logic             tc_o,
    output logic             evt_o,
    output logic [WIDTH-1:0] nxt_o
);

    logic at_end;
    logic [WIDTH-1:0] end_val;

    always_comb begin
        at_end  = up_i ? (data_i == MAX_CNT) : (data_i == '0);
        // Saturating mode parks on the current end; wrapping jumps to the opposite end.
        end_val = (SATURATE == MODE_SAT) ? data_i : (up_i ? '0 : MAX_CNT);
        tc_o    = at_end;
        evt_o   = ce_i && at_end;
        nxt_o   = !ce_i ? data_i : at_end ? end_val : up_i ? data_i + 1'b1 : data_i - 1'b1;
    end

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: loadable up/down modulo counter with wrap/saturate mode, wrap pulse and sticky overflow.
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter bit SATURATE = MODE_WRAP
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DAT_I,
    output logic [WIDTH-1:0] DATA_O,
    output logic             TC_O,
    output logic             WRAP_O,
    output logic             OVF_O
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(max_cnt(MODULUS));

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("updown_mod_counter: MODULUS must lie in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] data_q, data_d, nxt;
    logic             wrap_q, wrap_d, ovf_q, ovf_d, evt;

    range_end_detect #(
        .WIDTH    (WIDTH),
        .MAX_CNT  (MAX_CNT),
        .SATURATE (SATURATE)
    ) u_red (
        .data_i (data_q),
        .up_i   (UP),
        .ce_i   (CE),
        .tc_o   (TC_O),
        .evt_o  (evt),
        .nxt_o  (nxt)
    );

    always_comb begin
        data_d = LOAD ? ((DAT_I > MAX_CNT) ? MAX_CNT : DAT_I) : nxt;
        wrap_d = !LOAD && evt && (SATURATE == MODE_WRAP);
        ovf_d  = !LOAD && (ovf_q || evt);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign DATA_O = data_q;
    assign WRAP_O = wrap_q;
    assign OVF_O  = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: three counter configurations driven in lockstep, checked by a queued integer model.
module tb_updown_mod_counter;

    logic clk = 1'b0;
    logic rst, ce, up, ld;
    logic [3:0] d;
    logic [3:0] d_a, d_b;
    logic [2:0] d_c;
    logic [2:0] tc, wr, ov;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0][3:0] data;
        logic [2:0]      wrap;
        logic [2:0]      ovf;
        logic [2:0]      tc;
    } exp_t;

    exp_t q[$];
    int   m_cnt[3];
    bit   m_ovf[3];

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_wrap (
        .CLK(clk), .RST(rst), .CE(ce), .UP(up), .LOAD(ld), .DAT_I(d),
        .DATA_O(d_a), .TC_O(tc[0]), .WRAP_O(wr[0]), .OVF_O(ov[0]));

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_sat (
        .CLK(clk), .RST(rst), .CE(ce), .UP(up), .LOAD(ld), .DAT_I(d),
        .DATA_O(d_b), .TC_O(tc[1]), .WRAP_O(wr[1]), .OVF_O(ov[1]));

    updown_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) dut_full (
        .CLK(clk), .RST(rst), .CE(ce), .UP(up), .LOAD(ld), .DAT_I(d[2:0]),
        .DATA_O(d_c), .TC_O(tc[2]), .WRAP_O(wr[2]), .OVF_O(ov[2]));

    function automatic int modn(int k);
        return k == 2 ? 8 : 10;
    endfunction

    function automatic int got_data(int k);
        return k == 0 ? int'(d_a) : k == 1 ? int'(d_b) : int'(d_c);
    endfunction

    task automatic chk(string nm, int k, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s[dut%0d] @%0t: got %0d expected %0d", nm, k, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            m_ovf[k] = 0;
        end
    endtask

    // Drive one cycle of stimulus and queue the state expected after the next rising edge.
    task automatic cyc(bit l, bit c, bit u, int dv);
        exp_t e;
        @(negedge clk);
        ld = l; ce = c; up = u; d = 4'(dv);
        e = '0;
        for (int k = 0; k < 3; k++) begin
            int m = modn(k);
            int n;
            bit w = 0;
            if (l) begin
                n = (k == 2) ? dv % 8 : dv;
                m_cnt[k] = (n > m - 1) ? m - 1 : n;
                m_ovf[k] = 0;
            end else if (c) begin
                n = m_cnt[k] + (u ? 1 : -1);
                if (n < 0 || n >= m) begin
                    m_ovf[k] = 1;
                    if (k != 1) begin
                        w = 1;
                        m_cnt[k] = (n + m) % m;
                    end
                end else begin
                    m_cnt[k] = n;
                end
            end
            e.data[k] = 4'(m_cnt[k]);
            e.wrap[k] = w;
            e.ovf[k]  = m_ovf[k];
            e.tc[k]   = u ? (m_cnt[k] == m - 1) : (m_cnt[k] == 0);
        end
        q.push_back(e);
    endtask

    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk("data", k, got_data(k), int'(e.data[k]));
                    chk("wrap", k, int'(wr[k]), int'(e.wrap[k]));
                    chk("ovf",  k, int'(ov[k]), int'(e.ovf[k]));
                    chk("tc",   k, int'(tc[k]), int'(e.tc[k]));
                end
            end
        end
    end

    task automatic async_reset_check();
        @(negedge clk);
        ld = 0; ce = 0; up = 0;
        #2 rst = 1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_data", k, got_data(k), 0);
            chk("rst_wrap", k, int'(wr[k]), 0);
            chk("rst_ovf",  k, int'(ov[k]), 0);
            chk("rst_tc_dn", k, int'(tc[k]), 1);
        end
        up = 1;
        #1;
        for (int k = 0; k < 3; k++) chk("rst_tc_up", k, int'(tc[k]), 0);
        #16;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    initial begin
        rst = 1; ce = 0; up = 1; ld = 0; d = 0;
        model_reset();
        #12 rst = 0;
        cyc(1, 0, 1, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1, 1, 0);
            cyc(0, 0, 1, 0);
        end
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 4);
        cyc(1, 0, 0, 10);
        cyc(1, 1, 1, 3);
        cyc(1, 0, 1, 8);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
        cyc(1, 0, 1, 7);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 0);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) != 0 ? up : !up, $urandom_range(0, 15));
        async_reset_check();
        for (int i = 0; i < 30; i++)
            cyc(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the team's 4-bit up/down loadable counter FSM: generalised width and modulus, with selectable wrap or saturate mode.
- Adds a terminal-count flag, a registered wrap pulse and a sticky overflow flag.
- Sits as a reusable count/timebase element driven by one-cycle CE strobes from control logic; DATA_O feeds displays and downstream sequencers.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 10, count range is 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at the range ends, 1 = hold at the range ends.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- CE  input  1  count enable, level-sampled each rising edge.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- LOAD  input  1  synchronous parallel load.
- DAT_I  input  WIDTH  load value.
- DATA_O  output  WIDTH  current count, registered.
- TC_O  output  1  terminal count, combinational from DATA_O and UP.
- WRAP_O  output  1  one-cycle registered pulse on a range-end event.
- OVF_O  output  1  sticky range-end flag, registered.

Behaviour:
- One clock; reset is asynchronous and active-high (CLK, RST).
- Reset values, effective immediately on RST assertion regardless of CLK:
  - DATA_O = 0
  - WRAP_O = 0
  - OVF_O = 0
- Reset mid-count aborts the count. The first edge after RST deasserts evaluates normally.
- Per-edge priority: RST > LOAD > CE > hold.
- LOAD = 1:
  - DATA_O <= DAT_I if DAT_I <= MODULUS-1, else MODULUS-1 (clamped).
  - OVF_O <= 0 and WRAP_O <= 0.
  - CE is ignored on that edge.
- CE = 1, LOAD = 0, UP = 1:
  - If DATA_O < MODULUS-1: DATA_O <= DATA_O+1.
  - Else this is a range-end event: DATA_O <= 0 if SATURATE=0, unchanged if SATURATE=1.
- CE = 1, LOAD = 0, UP = 0:
  - If DATA_O > 0: DATA_O <= DATA_O-1.
  - Else this is a range-end event: DATA_O <= MODULUS-1 if SATURATE=0, unchanged if SATURATE=1.
- Range-end event:
  - WRAP_O <= 1 for exactly one cycle, only when SATURATE=0.
  - OVF_O <= 1 in both modes, held until the next LOAD or RST.
- On every edge that is not a wrapping range-end event, WRAP_O <= 0.
- CE = 0, LOAD = 0: DATA_O holds, WRAP_O <= 0, OVF_O holds.
- TC_O = (UP && DATA_O == MODULUS-1) || (!UP && DATA_O == 0). It is independent of CE and changes immediately when UP changes.
- Latency: DATA_O updates on the same edge that samples CE/LOAD. WRAP_O and OVF_O assert on that same edge, alongside the new DATA_O value.
- Arithmetic: comparisons use WIDTH-bit unsigned values, with MODULUS-1 truncated to WIDTH bits. With MODULUS = 2**WIDTH, wrap is the natural modular roll-over and clamping never triggers.
- Direction change between consecutive CE edges needs no idle cycle.

Decomposition:
- Shared counter package:
  - Mode constants MODE_WRAP = 0 and MODE_SAT = 1.
  - A MAX_CNT constant derived from MODULUS.
  - An elaboration-time check of the MODULUS range.
- A single sub-module, range_end_detect, is natural. It is combinational and produces TC_O plus the next-value and event signals from DATA_O, UP and CE.
- The top level holds the DATA_O, WRAP_O and OVF_O registers.

Test Plan:
- Reset, defaults: RST high for 20 ns mid-simulation with UP=0 -> DATA_O=0, WRAP_O=0, OVF_O=0, TC_O=1 without waiting for a clock edge. Then UP=1 -> TC_O=0 immediately.
- Up wrap, defaults: UP=1, CE toggled high/low for 12 high edges from 0 -> DATA_O steps 1..9 then 0,1,2. WRAP_O is high for the single cycle after 9->0. OVF_O=1 from that edge on. TC_O=1 while DATA_O=9.
- Down wrap: from DATA_O=2, UP=0, 4 CE edges -> 1,0,9,8. WRAP_O pulses once on 0->9. OVF_O stays 1.
- Load, clamp, priority: DAT_I=4, LOAD for 1 cycle -> DATA_O=4, OVF_O=0. DAT_I=0xA with LOAD -> DATA_O=9 (clamped). LOAD=1 and CE=1 together with DAT_I=3 -> DATA_O=3, no increment.
- Saturate, SATURATE=1: load 8, UP=1, 3 CE edges -> 9,9,9. WRAP_O never asserts. OVF_O=1 after the second edge. UP=0 with 10 CE edges -> reaches 0 and holds 0.
- Full-range roll-over, WIDTH=3, MODULUS=8: count up from 7 -> 0 with a WRAP_O pulse. LOAD DAT_I=7 -> 7, no clamp. Assert RST between CE edges -> DATA_O=0 asynchronously.
